mac_tx_framegen: RTL

MAC_TX_FRAMEGEN -- requirements
Module: mac_tx_framegen

---
 rtl/cmn_params.sv | 7 +
 rtl/mac_params.sv | 33 +++
 rtl/cmn_sat_cnt.sv | 19 +
 rtl/mac_tx_framegen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cmn_params.sv
// rtl/cmn_params.sv - shared datapath geometry for the XGMII-side blocks
package cmn_params;

    localparam int N_CHANNELS = 4;
    localparam int W_BYTE     = 8;

endpackage

// File: rtl/mac_params.sv
// rtl/mac_params.sv - MAC TX symbols, preamble, counter widths and framer state type
package mac_params;

    import cmn_params::*;

    localparam logic [W_BYTE-1:0] SYM_IDLE  = 8'h07;
    localparam logic [W_BYTE-1:0] SYM_START = 8'hFB;
    localparam logic [W_BYTE-1:0] SYM_TERM  = 8'hFD;
    localparam logic [W_BYTE-1:0] SYM_ERROR = 8'hFE;
    localparam logic [W_BYTE-1:0] SYM_SFD   = 8'hD5;
    localparam logic [W_BYTE-1:0] SYM_PRE   = 8'h55;

    localparam int MAC_HDR_CNT   = 2;
    localparam int W_MAC_HDR_CNT = $clog2(MAC_HDR_CNT);
    localparam int N_PRE_BYTES   = MAC_HDR_CNT * N_CHANNELS;
    localparam int W_PRE_IDX     = $clog2(N_PRE_BYTES);

    // Index 0 is the first byte on the wire (lane 0 of header word 0).
    localparam logic [N_PRE_BYTES-1:0][W_BYTE-1:0] MAC_PREAMBLE =
        {SYM_SFD, {6{SYM_PRE}}, SYM_START};

    localparam int W_FRAME_CNT = 32;
    localparam int W_ERR_CNT   = 16;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_HDR  = 5'b00010,
        ST_DATA = 5'b00100,
        ST_IFG  = 5'b01000,
        ST_ERR  = 5'b10000
    } framegen_state_t;

endpackage

// File: rtl/cmn_sat_cnt.sv
// rtl/cmn_sat_cnt.sv - saturating up-counter with synchronous clear
module cmn_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge i_clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mac_tx_framegen.sv
// rtl/mac_tx_framegen.sv - builds XGMII TX words (preamble, payload, idle, error) from mac_tx_ctrl strobes
module mac_tx_framegen
    import cmn_params::*;
    import mac_params::*;
(
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_clk_en,
    input  logic [W_MAC_HDR_CNT-1:0]             i_hdr_id,
    input  logic                                 i_gen_hdr,
    input  logic                                 i_gen_data,
    input  logic                                 i_gen_idle,
    input  logic                                 i_gen_ifg,
    input  logic                                 i_gen_error,
    input  logic                                 i_buf_empty,
    input  logic [N_CHANNELS-1:0]                i_buf_rctrl,
    input  logic [N_CHANNELS-1:0][W_BYTE-1:0]    i_buf_rdata,
    output logic [N_CHANNELS-1:0]                o_xgmii_txc,
    output logic [N_CHANNELS-1:0][W_BYTE-1:0]    o_xgmii_txd,
    output logic [W_FRAME_CNT-1:0]               o_frame_cnt,
    output logic [W_ERR_CNT-1:0]                 o_err_cnt,
    output logic                                 o_underrun
);

    framegen_state_t                      state, state_nxt;
    logic [W_MAC_HDR_CNT:0]               hdr_cnt, hdr_cnt_nxt;
    logic [N_CHANNELS-1:0]                txc_nxt;
    logic [N_CHANNELS-1:0][W_BYTE-1:0]    txd_nxt;
    logic                                 underrun_nxt;
    logic                                 frame_inc;
    logic                                 err_inc;
    logic                                 has_term;
    logic                                 hdr_ok;
    logic                                 hdr_done;
    logic                                 underrun;
    logic [W_PRE_IDX-1:0]                 pidx;

    // hdr_cnt counts header words already emitted, so it doubles as the next expected id.
    assign hdr_ok   = ((state == ST_IDLE) || (state == ST_HDR)) &&
                      ({1'b0, i_hdr_id} == hdr_cnt);
    assign hdr_done = (hdr_cnt == (W_MAC_HDR_CNT+1)'(MAC_HDR_CNT));
    assign underrun = i_gen_data && i_buf_empty;

    always_comb begin
        has_term = 1'b0;
        for (int j = 0; j < N_CHANNELS; j++) begin
            if (i_buf_rctrl[j] && (i_buf_rdata[j] == SYM_TERM)) has_term = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            hdr_cnt <= '0;
        end else if (i_clk_en) begin
            state   <= state_nxt;
            hdr_cnt <= hdr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hdr_cnt_nxt = hdr_cnt;
        if (i_gen_error) begin
            state_nxt = ST_ERR;
        end else if (!i_gen_hdr && underrun) begin
            state_nxt = ST_ERR;
        end else begin
            unique case (state)
                ST_IDLE, ST_HDR: begin
                    if (i_gen_hdr) begin
                        state_nxt   = hdr_ok ? ST_HDR : ST_ERR;
                        hdr_cnt_nxt = hdr_cnt + 1'b1;
                    end else if (i_gen_data) begin
                        if (state == ST_HDR && hdr_done) state_nxt = has_term ? ST_IFG : ST_DATA;
                        else                             state_nxt = ST_ERR;
                    end else if ((i_gen_idle || i_gen_ifg) && state == ST_HDR) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_DATA: begin
                    if (i_gen_hdr || i_gen_idle || i_gen_ifg) state_nxt = ST_ERR;
                    else if (i_gen_data && has_term)          state_nxt = ST_IFG;
                end
                ST_IFG: begin
                    if (i_gen_hdr)       state_nxt = ST_ERR;
                    else if (i_gen_idle) state_nxt = ST_IDLE;
                end
                ST_ERR: begin
                    if (i_gen_idle || i_gen_ifg) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (state_nxt != ST_HDR) hdr_cnt_nxt = '0;
    end

    always_comb begin
        txc_nxt      = '1;
        txd_nxt      = {N_CHANNELS{SYM_IDLE}};
        underrun_nxt = 1'b0;
        frame_inc    = 1'b0;
        pidx         = '0;
        if (i_gen_error) begin
            txd_nxt = {N_CHANNELS{SYM_ERROR}};
        end else if (i_gen_hdr) begin
            if (hdr_ok) begin
                for (int j = 0; j < N_CHANNELS; j++) begin
                    pidx       = W_PRE_IDX'(int'(i_hdr_id) * N_CHANNELS + j);
                    txd_nxt[j] = MAC_PREAMBLE[pidx];
                    txc_nxt[j] = (pidx == '0);
                end
            end else begin
                txd_nxt = {N_CHANNELS{SYM_ERROR}};
            end
        end else if (i_gen_data) begin
            if (i_buf_empty) begin
                txd_nxt      = {N_CHANNELS{SYM_ERROR}};
                underrun_nxt = 1'b1;
            end else if (state == ST_DATA || state == ST_IFG || (state == ST_HDR && hdr_done)) begin
                txc_nxt   = i_buf_rctrl;
                txd_nxt   = i_buf_rdata;
                frame_inc = has_term && (state != ST_IFG);
            end else begin
                txd_nxt = {N_CHANNELS{SYM_ERROR}};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_xgmii_txc <= '1;
            o_xgmii_txd <= {N_CHANNELS{SYM_IDLE}};
            o_underrun  <= 1'b0;
        end else begin
            o_underrun <= i_clk_en && underrun_nxt;
            if (i_clk_en) begin
                o_xgmii_txc <= txc_nxt;
                o_xgmii_txd <= txd_nxt;
            end
        end
    end

    assign err_inc = (state_nxt == ST_ERR) && (state != ST_ERR);

    cmn_sat_cnt #(.W(W_FRAME_CNT)) u_frame_cnt (
        .i_clk (i_clk),
        .inc   (i_clk_en && frame_inc),
        .clr   (i_reset),
        .cnt   (o_frame_cnt)
    );

    cmn_sat_cnt #(.W(W_ERR_CNT)) u_err_cnt (
        .i_clk (i_clk),
        .inc   (i_clk_en && err_inc),
        .clr   (i_reset),
        .cnt   (o_err_cnt)
    );

    a_strobe_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
        i_clk_en |-> $onehot0({i_gen_hdr, i_gen_data, i_gen_idle, i_gen_ifg, i_gen_error}));

endmodule
